// File: rtl/wb_port_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | wb_port_arbiter_pkg : shared types/constants for the WB write-port arbiter |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package wb_port_arbiter_pkg;

   localparam int AW        = 5;
   localparam int DW        = 32;
   localparam int RET_DEPTH = 2;

   localparam logic [AW-1:0] X0_ADDR = '0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_wr_t;

endpackage

`default_nettype wire

// File: rtl/wb_ret_fifo.sv
// +----------------------------------------------------------------------------+
// | wb_ret_fifo : 2-entry load-return buffer with per-entry invalidation       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_ret_fifo
   import wb_port_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  wb_wr_t        push_entry_i,
   input  logic          pop_i,
   input  logic          inval_i,
   input  logic [AW-1:0] inval_addr_i,
   output wb_wr_t        head_o,
   output logic          head_live_o,
   output logic [1:0]    count_o
);

   wb_wr_t               entry_q [RET_DEPTH];
   logic [RET_DEPTH-1:0] live_q, live_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic [1:0]           count_q, count_d;

   // An invalidated entry keeps its slot so ordering is preserved; it is
   // simply drained later without producing a write.
   always_comb begin
      live_d   = live_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (inval_i) begin
         for (int i = 0; i < RET_DEPTH; i++) begin
            if (entry_q[i].addr == inval_addr_i) begin
               live_d[i] = 1'b0;
            end
         end
      end
      if (pop_i) begin
         live_d[rd_ptr_q] = 1'b0;
         rd_ptr_d         = ~rd_ptr_q;
      end
      if (push_i) begin
         live_d[wr_ptr_q] = 1'b1;
         wr_ptr_d         = ~wr_ptr_q;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q   <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         live_q   <= live_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         entry_q[wr_ptr_q] <= push_entry_i;
      end
   end

   assign head_o      = entry_q[rd_ptr_q];
   assign head_live_o = live_q[rd_ptr_q];
   assign count_o     = count_q;

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | wb_port_arbiter : register-file write-port arbiter (pipe > buffer > load)  |
// | Optional busy scoreboard via macro WB_ARB_SCOREBOARD_EN.   Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pipe_wen,
   input  logic [AW-1:0] pipe_addr,
   input  logic [DW-1:0] pipe_data,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_addr,
   input  logic [AW-1:0] rs1_addr,
   input  logic [AW-1:0] rs2_addr,
   output logic          rs1_busy,
   output logic          rs2_busy,
   output logic          rf_wen,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic [1:0]    pend_cnt
);

   logic          ld_acc, head_pop, bypass, push, inval;
   logic          head_live, win_valid, load_wr;
   logic [1:0]    fifo_cnt;
   wb_wr_t        head, win, ld_entry;
   logic          rf_wen_q;
   logic [AW-1:0] rf_waddr_q;
   logic [DW-1:0] rf_wdata_q;

   assign ld_entry = '{addr: ld_addr, data: ld_data};
   assign ld_ready = (fifo_cnt < 2'(RET_DEPTH));
   assign ld_acc   = ld_valid & ld_ready;
   assign head_pop = ~pipe_wen & (fifo_cnt != 2'd0);
   assign bypass   = ~pipe_wen & (fifo_cnt == 2'd0) & ld_acc;
   assign inval    = pipe_wen & (pipe_addr != X0_ADDR);
   // A losing return is dropped rather than buffered when it targets x0 or
   // is superseded by a same-cycle pipe write to the same register.
   assign push     = ld_acc & ~bypass & (ld_addr != X0_ADDR)
                   & ~(pipe_wen & (pipe_addr == ld_addr));

   wb_ret_fifo u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push),
      .push_entry_i (ld_entry),
      .pop_i        (head_pop),
      .inval_i      (inval),
      .inval_addr_i (pipe_addr),
      .head_o       (head),
      .head_live_o  (head_live),
      .count_o      (fifo_cnt)
   );

   always_comb begin
      win_valid = 1'b0;
      win       = '0;
      load_wr   = 1'b0;
      if (pipe_wen) begin
         win_valid = (pipe_addr != X0_ADDR);
         win       = '{addr: pipe_addr, data: pipe_data};
      end else if (head_pop) begin
         win_valid = head_live;
         win       = head;
         load_wr   = head_live;
      end else if (bypass) begin
         win_valid = (ld_addr != X0_ADDR);
         win       = ld_entry;
         load_wr   = (ld_addr != X0_ADDR);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rf_wen_q <= win_valid;
         if (win_valid) begin
            rf_waddr_q <= win.addr;
            rf_wdata_q <= win.data;
         end
      end
   end

   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign pend_cnt = fifo_cnt;

`ifdef WB_ARB_SCOREBOARD_EN
   logic [31:1] busy_q, busy_d;

   // Set is applied after clear so an issue and a retiring load to the same
   // register in one cycle leave it pending.
   always_comb begin
      busy_d = busy_q;
      if (load_wr) begin
         busy_d[win.addr] = 1'b0;
      end
      if (iss_valid && (iss_addr != X0_ADDR)) begin
         busy_d[iss_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign rs1_busy = (rs1_addr != X0_ADDR) &&
                     (busy_q[rs1_addr] || (iss_valid && (iss_addr == rs1_addr)));
   assign rs2_busy = (rs2_addr != X0_ADDR) &&
                     (busy_q[rs2_addr] || (iss_valid && (iss_addr == rs2_addr)));
`else
   logic unused_sb;
   assign unused_sb = ^{iss_valid, iss_addr, rs1_addr, rs2_addr, load_wr};
   assign rs1_busy  = 1'b0;
   assign rs2_busy  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_wb_port_arbiter : directed self-checking bench with write scoreboard    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_wen;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        ld_valid;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [1:0]  pend_cnt;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wb_port_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pipe_wen  (pipe_wen),
      .pipe_addr (pipe_addr),
      .pipe_data (pipe_data),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_busy  (rs1_busy),
      .rs2_busy  (rs2_busy),
      .rf_wen    (rf_wen),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .pend_cnt  (pend_cnt)
   );

   // Every register-file write is matched in order against the expected queue.
   always @(negedge clk) begin
      exp_t e;
      if (rf_wen !== 1'b0) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write observed rf_wen=%b addr=%0d data=%h expected no write",
                   rf_wen, rf_waddr, rf_wdata);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert ({rf_wen, rf_waddr, rf_wdata} === {1'b1, e.addr, e.data}) else begin
               errors++;
               $error("FAIL write_order observed wen=%b addr=%0d data=%h expected addr=%0d data=%h",
                      rf_wen, rf_waddr, rf_wdata, e.addr, e.data);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic idle_inputs();
      pipe_wen  = 1'b0;
      pipe_addr = '0;
      pipe_data = '0;
      ld_valid  = 1'b0;
      ld_addr   = '0;
      ld_data   = '0;
      iss_valid = 1'b0;
      iss_addr  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pipe(input logic [4:0] a, input logic [31:0] d);
      pipe_wen  = 1'b1;
      pipe_addr = a;
      pipe_data = d;
      if (a != 5'd0) exp_q.push_back('{addr: a, data: d});
   endtask

   task automatic drive_ld(input logic [4:0] a, input logic [31:0] d);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
   endtask

   initial begin
      rst_n    = 1'b0;
      rs1_addr = '0;
      rs2_addr = '0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rf_wen",   32'(rf_wen),   32'd0);
      chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_rf_wdata", rf_wdata,      32'd0);
      chk("rst_pend",     32'(pend_cnt), 32'd0);
      chk("rst_ld_ready", 32'(ld_ready), 32'd1);

      // first write in the very first cycle after release
      rst_n = 1'b1;
      drive_pipe(5'd5, 32'h11);
      tick();
      idle_inputs();
      chk("pipe_only_pend", 32'(pend_cnt), 32'd0);

      // pipe beats a load; load written the following cycle
      drive_pipe(5'd3, 32'h33);
      drive_ld(5'd7, 32'hAA);
      exp_q.push_back('{addr: 5'd7, data: 32'hAA});
      tick();
      idle_inputs();
      chk("collide_pend1", 32'(pend_cnt), 32'd1);
      tick();
      chk("collide_pend0", 32'(pend_cnt), 32'd0);

      // bypass with empty buffer
      drive_ld(5'd8, 32'h88);
      exp_q.push_back('{addr: 5'd8, data: 32'h88});
      tick();
      idle_inputs();
      chk("bypass_pend", 32'(pend_cnt), 32'd0);

      // simultaneous push and pop at one entry
      drive_pipe(5'd2, 32'h22);
      drive_ld(5'd15, 32'hF1);
      exp_q.push_back('{addr: 5'd15, data: 32'hF1});
      tick();
      idle_inputs();
      chk("pushpop_pend_a", 32'(pend_cnt), 32'd1);
      drive_ld(5'd16, 32'hF2);
      exp_q.push_back('{addr: 5'd16, data: 32'hF2});
      chk("pushpop_ready", 32'(ld_ready), 32'd1);
      tick();
      idle_inputs();
      chk("pushpop_pend_b", 32'(pend_cnt), 32'd1);
      tick();
      chk("pushpop_pend_c", 32'(pend_cnt), 32'd0);

      // fill to two entries under continuous pipe traffic, then drain
      drive_pipe(5'd20, 32'h200);
      drive_ld(5'd11, 32'hB1);
      chk("fill_ready0", 32'(ld_ready), 32'd1);
      tick();
      chk("fill_pend1", 32'(pend_cnt), 32'd1);
      drive_pipe(5'd21, 32'h201);
      drive_ld(5'd13, 32'hB3);
      tick();
      chk("fill_pend2",  32'(pend_cnt), 32'd2);
      chk("fill_ready2", 32'(ld_ready), 32'd0);
      drive_pipe(5'd22, 32'h202);
      drive_ld(5'd14, 32'hB4);
      tick();
      idle_inputs();
      chk("fill_hold", 32'(pend_cnt), 32'd2);
      exp_q.push_back('{addr: 5'd11, data: 32'hB1});
      exp_q.push_back('{addr: 5'd13, data: 32'hB3});
      tick();
      chk("drain_pend1",  32'(pend_cnt), 32'd1);
      chk("drain_ready1", 32'(ld_ready), 32'd1);
      tick();
      chk("drain_pend0", 32'(pend_cnt), 32'd0);

      // younger pipe write invalidates buffered entry
      drive_pipe(5'd1, 32'h01);
      drive_ld(5'd9, 32'h99);
      tick();
      idle_inputs();
      chk("inval_pend1", 32'(pend_cnt), 32'd1);
      drive_pipe(5'd9, 32'h55);
      tick();
      idle_inputs();
      chk("inval_pend_keep", 32'(pend_cnt), 32'd1);
      tick();
      chk("inval_pend0", 32'(pend_cnt), 32'd0);
      tick();

      // same-cycle pipe and bypassing load to one address
      drive_pipe(5'd6, 32'h66);
      drive_ld(5'd6, 32'h77);
      tick();
      idle_inputs();
      chk("same_addr_pend", 32'(pend_cnt), 32'd0);
      tick();

      // x0 writes discarded from every source
      drive_pipe(5'd0, 32'hDEAD);
      tick();
      drive_ld(5'd0, 32'hBEEF);
      tick();
      drive_pipe(5'd4, 32'h44);
      drive_ld(5'd0, 32'hCAFE);
      tick();
      idle_inputs();
      chk("x0_pend", 32'(pend_cnt), 32'd0);
      tick();

`ifdef WB_ARB_SCOREBOARD_EN
      rs1_addr  = 5'd4;
      rs2_addr  = 5'd5;
      iss_valid = 1'b1;
      iss_addr  = 5'd4;
      #1;
      chk("sb_issue_fwd", 32'(rs1_busy), 32'd1);
      chk("sb_rs2_idle",  32'(rs2_busy), 32'd0);
      tick();
      idle_inputs();
      chk("sb_held", 32'(rs1_busy), 32'd1);
      drive_ld(5'd4, 32'h4444);
      exp_q.push_back('{addr: 5'd4, data: 32'h4444});
      #1;
      chk("sb_before_wr", 32'(rs1_busy), 32'd1);
      tick();
      idle_inputs();
      chk("sb_cleared", 32'(rs1_busy), 32'd0);
      iss_valid = 1'b1;
      iss_addr  = 5'd5;
      tick();
      drive_ld(5'd5, 32'h5151);
      exp_q.push_back('{addr: 5'd5, data: 32'h5151});
      tick();
      idle_inputs();
      chk("sb_set_wins", 32'(rs2_busy), 32'd1);
      drive_ld(5'd5, 32'h5252);
      exp_q.push_back('{addr: 5'd5, data: 32'h5252});
      tick();
      idle_inputs();
      chk("sb_clear5", 32'(rs2_busy), 32'd0);
      rs1_addr  = 5'd12;
      iss_valid = 1'b1;
      iss_addr  = 5'd12;
      tick();
      idle_inputs();
      drive_pipe(5'd1, 32'h0101);
      drive_ld(5'd12, 32'h1212);
      exp_q.push_back('{addr: 5'd12, data: 32'h1212});
      tick();
      idle_inputs();
      chk("sb_buffered", 32'(rs1_busy), 32'd1);
      tick();
      chk("sb_deq_clear", 32'(rs1_busy), 32'd0);
`else
      rs1_addr  = 5'd4;
      rs2_addr  = 5'd4;
      iss_valid = 1'b1;
      iss_addr  = 5'd4;
      #1;
      chk("nosb_rs1", 32'(rs1_busy), 32'd0);
      chk("nosb_rs2", 32'(rs2_busy), 32'd0);
      tick();
      idle_inputs();
      chk("nosb_rs1_after", 32'(rs1_busy), 32'd0);
`endif

      // reset with a full buffer discards both entries
      drive_pipe(5'd1, 32'h101);
      drive_ld(5'd17, 32'h17);
      tick();
      drive_pipe(5'd2, 32'h102);
      drive_ld(5'd18, 32'h18);
      tick();
      idle_inputs();
      chk("prerst_pend", 32'(pend_cnt), 32'd2);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_wen",   32'(rf_wen),   32'd0);
      chk("midrst_waddr", 32'(rf_waddr), 32'd0);
      chk("midrst_wdata", rf_wdata,      32'd0);
      chk("midrst_pend",  32'(pend_cnt), 32'd0);
      chk("midrst_busy",  32'({rs1_busy, rs2_busy}), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) tick();
      chk("postrst_pend", 32'(pend_cnt), 32'd0);

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL missing_writes observed %0d outstanding expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 pipe_wen / pipe_addr / pipe_data  in  1/5/32  in-order WB-stage write; no backpressure.
REQ-005 ld_valid / ld_addr / ld_data  in  1/5/32  long-latency load return.
REQ-006 ld_ready  out  1  load return accepted this cycle.
REQ-007 iss_valid / iss_addr  in  1/5  long-latency op issued; destination becomes pending.
REQ-008 rs1_addr / rs2_addr  in  5/5  decode source operands.
REQ-009 rs1_busy / rs2_busy  out  1/1  combinational: source is pending.
REQ-010 rf_wen / rf_waddr / rf_wdata  out  1/5/32  registered register-file write port.
REQ-011 pend_cnt  out  2  valid entries in the return buffer.

Function
REQ-012 SHALL arbitrate the single register-file write port; the pipe has fixed highest priority.
REQ-013 rf_* SHALL be driven one cycle after the winning request is sampled.
REQ-014 Priority each cycle: pipe_wen, then buffer head, then ld_valid bypass (buffer empty only).
REQ-015 Writes to address 0 SHALL be discarded: no rf_wen, no buffer entry, no scoreboard change.
REQ-016 The return buffer SHALL be a 2-entry FIFO {addr, data} with wrapping 1-bit pointers.
REQ-017 ld_ready SHALL be 1 iff pend_cnt < 2 (combinational from state, not from ld_valid).
REQ-018 Accepted ld return SHALL be enqueued when it loses arbitration; written directly when it wins.
REQ-019 Simultaneous enqueue and dequeue with pend_cnt = 2 SHALL NOT occur (ld_ready = 0); at pend_cnt = 1 count is unchanged.
REQ-020 A pipe write whose address matches a valid buffer entry SHALL invalidate that entry (younger wins); invalidated entries are dequeued without rf_wen.
REQ-021 Same-cycle pipe write and bypassing ld return to the same address: pipe writes, ld return is dropped.

Reset
REQ-022 On rst_n low: rf_wen = 0, rf_waddr = 0, rf_wdata = 0, pend_cnt = 0, pointers = 0, all busy bits = 0.
REQ-023 Reset mid-operation SHALL discard buffered returns and pending state without issuing writes.
REQ-024 First write SHALL be possible in the first cycle after rst_n deasserts.

Configuration
REQ-025 Macro WB_ARB_SCOREBOARD_EN compiles in a 31-bit busy scoreboard (x1..x31).
REQ-026 With it: iss_valid sets busy[iss_addr]; a load write (bypass or dequeue) clears busy[addr]; set and clear of the same address in one cycle leaves it set.
REQ-027 With it: rsN_busy = busy[rsN_addr], also 1 when the same-cycle iss_addr matches.
REQ-028 Without it: no busy state, rs1_busy = rs2_busy = 0, iss_* ignored.

Structure
REQ-029 Write-port record type, buffer depth constant and x0 index SHALL reside in the shared core package.
REQ-030 The 2-entry FIFO SHALL be a sub-module named wb_ret_fifo; arbitration and scoreboard stay in the top.

Verification
REQ-031 pipe_wen=1 addr 5 data 0x11 alone -> next cycle rf_wen=1, waddr 5, wdata 0x11.
REQ-032 pipe addr 3 and ld_valid addr 7 0xAA same cycle -> pipe written, then addr 7 0xAA written the following cycle, pend_cnt 1 then 0.
REQ-033 Pipe writes for 3 consecutive cycles, ld_valid held -> ld_ready 0 after pend_cnt=2; entries drain in order afterwards.
REQ-034 Buffered ld to addr 9, then pipe write addr 9 0x55 -> entry discarded; rf holds 0x55; no later write to 9.
REQ-035 With WB_ARB_SCOREBOARD_EN: iss addr 4, rs1_addr 4 -> rs1_busy 1 until ld to 4 is written; write to addr 0 -> no rf_wen.
REQ-036 Assert rst_n low with pend_cnt=2 -> all outputs 0 and no drained writes after release.
